// File: rtl/engine_pulse_bank_if.sv
// Control and status bundle between the engine-rev logic and the pulse bank.
// The master drives tick/enable/mode/length; the slave returns pulses and direction.
interface engine_pulse_bank_if #(
    parameter int CHANNELS = 2,
    parameter int LEN_W    = 16
);
    logic                      tick_en;
    logic [CHANNELS-1:0]       ch_enable;
    logic [CHANNELS-1:0]       mode;
    logic [CHANNELS*LEN_W-1:0] wave_length;
    logic [CHANNELS-1:0]       pulse_out;
    logic [CHANNELS-1:0]       dir_up;

    modport master (
        output tick_en, ch_enable, mode, wave_length,
        input  pulse_out, dir_up
    );

    modport slave (
        input  tick_en, ch_enable, mode, wave_length,
        output pulse_out, dir_up
    );
endinterface

// File: rtl/engine_pulse_bank.sv
// Bank of independent triangle/sawtooth sweep counters, each emitting a one-clock
// pulse when the tap bit below the counter's leading one rises.
module engine_pulse_bank #(
    parameter int CHANNELS    = 2,
    parameter int CNT_W       = 24,
    parameter int LEN_W       = 16,
    parameter int START_VALUE = 256,
    parameter int TAP_OFFSET  = 2
) (
    input  logic                clk,
    input  logic                rst_n,
    engine_pulse_bank_if.slave  bus
);
    localparam logic [CNT_W-1:0] START_CNT = CNT_W'(START_VALUE);

    generate
        for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_ch
            logic [CNT_W-1:0] cnt_q, cnt_d;
            logic [LEN_W-1:0] len_q, len_d;
            logic             dir_q, dir_d;
            logic             armed_q, armed_d;
            logic             pulse_q, pulse_d;
            logic [CNT_W-1:0] top;
            logic [LEN_W-1:0] len_in;
            logic             upd;
            logic             tap;

            assign len_in = bus.wave_length[gi*LEN_W +: LEN_W];
            assign upd    = bus.tick_en & bus.ch_enable[gi];
            assign top    = START_CNT + {{(CNT_W-LEN_W){1'b0}}, len_q};

            // Last hit wins, so tap ends up referenced to the highest set bit.
            always_comb begin
                tap = 1'b0;
                for (int b = TAP_OFFSET; b < CNT_W; b++) begin
                    if (cnt_q[b]) begin
                        tap = cnt_q[b - TAP_OFFSET];
                    end
                end
            end

            always_comb begin
                cnt_d   = cnt_q;
                len_d   = len_q;
                dir_d   = dir_q;
                armed_d = armed_q;
                pulse_d = 1'b0;
                if (upd) begin
                    if (tap) begin
                        if (armed_q) begin
                            pulse_d = 1'b1;
                            armed_d = 1'b0;
                        end
                    end else begin
                        armed_d = 1'b1;
                    end

                    if (bus.mode[gi]) begin
                        dir_d = 1'b1;
                        if (cnt_q >= top) begin
                            cnt_d = START_CNT;
                            len_d = len_in;
                        end else begin
                            cnt_d = cnt_q + 1'b1;
                        end
                    end else if (dir_q) begin
                        // Turning down from START would undershoot the sweep floor.
                        if (cnt_q >= top && cnt_q > START_CNT) begin
                            dir_d = 1'b0;
                            cnt_d = cnt_q - 1'b1;
                        end else begin
                            cnt_d = cnt_q + 1'b1;
                        end
                    end else begin
                        if (cnt_q <= START_CNT) begin
                            dir_d = 1'b1;
                            cnt_d = cnt_q + 1'b1;
                            len_d = len_in;
                        end else begin
                            cnt_d = cnt_q - 1'b1;
                        end
                    end
                end
            end

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    cnt_q   <= START_CNT + 1'b1;
                    len_q   <= '0;
                    dir_q   <= 1'b1;
                    armed_q <= 1'b1;
                    pulse_q <= 1'b0;
                end else begin
                    cnt_q   <= cnt_d;
                    len_q   <= len_d;
                    dir_q   <= dir_d;
                    armed_q <= armed_d;
                    pulse_q <= pulse_d;
                end
            end

            assign bus.pulse_out[gi] = pulse_q;
            assign bus.dir_up[gi]    = dir_q;
        end
    endgenerate
endmodule

// File: tb/tb_engine_pulse_bank.sv
// Directed bench for engine_pulse_bank: reset, triangle/sawtooth sweeps, length
// latching, pulse placement and per-channel gating.
module tb_engine_pulse_bank;
    localparam int CHANNELS = 2;
    localparam int CNT_W    = 24;
    localparam int LEN_W    = 16;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   failures = 0;

    engine_pulse_bank_if #(.CHANNELS(CHANNELS), .LEN_W(LEN_W)) bus ();

    engine_pulse_bank #(
        .CHANNELS(CHANNELS), .CNT_W(CNT_W), .LEN_W(LEN_W),
        .START_VALUE(256), .TAP_OFFSET(2)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .bus(bus.slave)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp_v);
        end
    endtask

    function automatic logic [31:0] cnt0();
        return 32'(dut.g_ch[0].cnt_q);
    endfunction

    function automatic logic [31:0] cnt1();
        return 32'(dut.g_ch[1].cnt_q);
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Asynchronous reset mid-cycle, checked before the next edge, released on negedge.
    task automatic pulse_reset(input string tag);
        #1 rst_n = 1'b0;
        #1;
        chk({tag, "_cnt0"}, cnt0(), 32'd257);
        chk({tag, "_cnt1"}, cnt1(), 32'd257);
        chk({tag, "_dir"}, 32'(bus.dir_up), 32'd3);
        chk({tag, "_pulse"}, 32'(bus.pulse_out), 32'd0);
        @(negedge clk) rst_n = 1'b1;
    endtask

    initial begin
        int tri_cnt [10] = '{256, 257, 258, 259, 260, 259, 258, 257, 256, 257};
        int tri_dir [10] = '{0, 1, 1, 1, 1, 0, 0, 0, 0, 1};
        int upd_cnt [17] = '{259, 260, 259, 258, 257, 256, 257, 258, 259, 260,
                             261, 262, 263, 264, 265, 266, 265};
        int saw_cnt [6]  = '{256, 257, 258, 259, 256, 257};
        int saw_cnt1 [6] = '{256, 257, 258, 259, 260, 259};
        int gate_cnt [3] = '{258, 259, 256};
        int npulse0, npulse1, first_k, second_k, cnt_at_pulse;

        bus.tick_en     = 1'b0;
        bus.ch_enable   = 2'b11;
        bus.mode        = 2'b00;
        bus.wave_length = {16'd4, 16'd4};

        // Power-on reset state
        repeat (2) @(posedge clk);
        #1;
        chk("por_cnt0", cnt0(), 32'd257);
        chk("por_dir", 32'(bus.dir_up), 32'd3);
        chk("por_pulse", 32'(bus.pulse_out), 32'd0);
        @(negedge clk) begin
            rst_n = 1'b1;
            bus.tick_en = 1'b1;
        end

        // Triangle sweep, len=4
        for (int i = 0; i < 10; i++) begin
            step();
            $display("tri  tick %0d cnt0=%0d dir=%b pulse=%b", i, cnt0(), bus.dir_up, bus.pulse_out);
            chk($sformatf("tri_cnt0_%0d", i), cnt0(), 32'(tri_cnt[i]));
            chk($sformatf("tri_cnt1_%0d", i), cnt1(), 32'(tri_cnt[i]));
            chk($sformatf("tri_dir0_%0d", i), 32'(bus.dir_up[0]), 32'(tri_dir[i]));
            chk($sformatf("tri_pulse_%0d", i), 32'(bus.pulse_out), 32'd0);
        end

        // Length change mid up-sweep takes effect only after the next lower turnaround
        step();
        chk("lenupd_pre", cnt0(), 32'd258);
        bus.wave_length = {16'd4, 16'd10};
        for (int i = 0; i < 17; i++) begin
            step();
            $display("len  tick %0d cnt0=%0d cnt1=%0d", i, cnt0(), cnt1());
            chk($sformatf("len_cnt0_%0d", i), cnt0(), 32'(upd_cnt[i]));
        end

        // Reset asserted mid-sweep, then two ticks after release
        pulse_reset("midrst");
        bus.wave_length = {16'd4, 16'd4};
        step();
        chk("after_rst_cnt0_a", cnt0(), 32'd256);
        step();
        chk("after_rst_cnt0_b", cnt0(), 32'd257);

        // Pulse placement, triangle len=100: one pulse per 200-tick period
        bus.wave_length = {16'd4, 16'd100};
        pulse_reset("prst");
        npulse0 = 0;
        npulse1 = 0;
        first_k = -1;
        second_k = -1;
        cnt_at_pulse = -1;
        for (int k = 1; k <= 400; k++) begin
            step();
            if (bus.pulse_out[1] === 1'b1) npulse1++;
            if (bus.pulse_out[0] === 1'b1) begin
                npulse0++;
                if (first_k < 0) begin
                    first_k = k;
                    cnt_at_pulse = int'(cnt0());
                end else if (second_k < 0) begin
                    second_k = k;
                end
                $display("pulse ch0 at tick %0d cnt0=%0d", k, cnt0());
            end
        end
        chk("pulse_count0", 32'(npulse0), 32'd2);
        chk("pulse_count1", 32'(npulse1), 32'd0);
        chk("pulse_first_tick", 32'(first_k), 32'd66);
        chk("pulse_second_tick", 32'(second_k), 32'd266);
        chk("pulse_post_cnt", 32'(cnt_at_pulse), 32'd321);

        // Sawtooth on ch0 (len=3), triangle on ch1 (len=4)
        bus.mode = 2'b01;
        bus.wave_length = {16'd4, 16'd3};
        pulse_reset("srst");
        for (int i = 0; i < 6; i++) begin
            step();
            $display("saw  tick %0d cnt0=%0d cnt1=%0d dir=%b", i, cnt0(), cnt1(), bus.dir_up);
            chk($sformatf("saw_cnt0_%0d", i), cnt0(), 32'(saw_cnt[i]));
            chk($sformatf("saw_dir0_%0d", i), 32'(bus.dir_up[0]), 32'd1);
            chk($sformatf("saw_cnt1_%0d", i), cnt1(), 32'(saw_cnt1[i]));
        end

        // Global tick gating
        bus.tick_en = 1'b0;
        for (int i = 0; i < 5; i++) begin
            step();
            $display("gate tick %0d cnt0=%0d cnt1=%0d", i, cnt0(), cnt1());
            chk($sformatf("gate_cnt0_%0d", i), cnt0(), 32'd257);
            chk($sformatf("gate_cnt1_%0d", i), cnt1(), 32'd259);
            chk($sformatf("gate_pulse_%0d", i), 32'(bus.pulse_out), 32'd0);
        end

        // Ch1 disabled while ch0 runs
        bus.tick_en = 1'b1;
        bus.ch_enable = 2'b01;
        for (int i = 0; i < 3; i++) begin
            step();
            $display("dis1 tick %0d cnt0=%0d cnt1=%0d", i, cnt0(), cnt1());
            chk($sformatf("dis_cnt0_%0d", i), cnt0(), 32'(gate_cnt[i]));
            chk($sformatf("dis_cnt1_%0d", i), cnt1(), 32'd259);
            chk($sformatf("dis_pulse1_%0d", i), 32'(bus.pulse_out[1]), 32'd0);
        end

        // Ch1 resumes downward from where it froze
        bus.ch_enable = 2'b11;
        step();
        $display("res  cnt0=%0d cnt1=%0d dir=%b", cnt0(), cnt1(), bus.dir_up);
        chk("resume_cnt0", cnt0(), 32'd257);
        chk("resume_cnt1", cnt1(), 32'd258);
        chk("resume_dir1", 32'(bus.dir_up[1]), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/engine_pulse_bank.md
Name: engine_pulse_bank

Overview:
Multi-channel successor to the single-channel engine pulse generator. Each channel runs a counter that sweeps between START_VALUE and START_VALUE+length, in triangle or sawtooth mode. Each channel emits a one-clock pulse on the rising edge of a tap bit that sits a fixed distance below the counter's leading one, so the pulse rate tracks the sweep length. Wave length is an external per-channel input, latched glitch-free at the lower turnaround. The block sits between the engine-rev logic and the sound mixer.

Parameters:
CHANNELS, 2, number of independent generator channels
CNT_W, 24, counter width per channel; must exceed LEN_W+1 and hold START_VALUE+2^LEN_W-1
LEN_W, 16, width of each wave-length input
START_VALUE, 256, lower sweep bound; scales output frequency down
TAP_OFFSET, 2, tap bit distance below the counter's highest set bit

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
tick_en  in  1  3 MHz clock-enable strobe; all counting is qualified by it
ch_enable  in  CHANNELS  per-channel run enable
mode  in  CHANNELS  per-channel mode: 0 = triangle, 1 = sawtooth
wave_length  in  CHANNELS*LEN_W  per-channel requested length; channel i uses bits [i*LEN_W +: LEN_W]
pulse_out  out  CHANNELS  per-channel one-clock output pulse
dir_up  out  CHANNELS  per-channel current sweep direction (status)

Behaviour:
- Reset (rst_n low, asynchronous, effective at any time including mid-sweep), per channel: cnt=START_VALUE+1, dir_up=1, len_active=0, armed=1, pulse_out=0.
- Channel i updates only on a clk edge where tick_en=1 and ch_enable[i]=1. Otherwise cnt, dir, len_active and armed hold, and pulse_out is 0.
- Top bound is TOP = START_VALUE + len_active, computed at CNT_W width with no overflow.
- Triangle mode (mode=0):
  - dir up, cnt>=TOP -> dir down, cnt-1.
  - dir down, cnt<=START_VALUE -> dir up, cnt+1, len_active<=wave_length[i].
  - otherwise cnt steps ±1 in the current direction.
- Sawtooth mode (mode=1):
  - cnt>=TOP -> cnt=START_VALUE, len_active<=wave_length[i], dir forced up.
  - otherwise cnt+1.
- wave_length changes take effect only at the next length latch event. len_active never changes mid-sweep.
- len_active=0: triangle alternates START_VALUE / START_VALUE+1; sawtooth holds START_VALUE.
- A mode change is applied at the next update. If cnt is below START_VALUE or direction is down in sawtooth, the channel forces up.
- Tap rule: msb = index of highest set bit of pre-update cnt. tap = cnt[msb-TAP_OFFSET] if msb>=TAP_OFFSET, else 0.
- Pulse rule, evaluated on each update cycle using the pre-update cnt:
  - tap=1 and armed -> pulse_out=1 for exactly that one clk cycle, armed=0.
  - tap=0 -> armed=1.
  - pulse_out returns to 0 on the next clk edge unconditionally.
- Latency: pulse_out is registered and rises on the clk edge of the qualifying tick.
- Channels are fully independent; no shared state.

Test Plan:
- Reset: run with len=4, assert rst_n low mid-sweep -> immediately cnt=257, dir_up=1, pulse_out=0. After release, ticks give cnt 256 (latch), 257.
- Triangle, len=4, from reset -> cnt 257,256,257,258,259,260,259,258,257,256,257; period 8 ticks; dir_up flips at 260 and 256.
- Pulse, triangle, len=100 -> exactly one pulse per period, on the tick with pre-update cnt=320 (bit6 rising). Re-armed after the down-sweep passes 319. pulse_out width is 1 clk.
- Length update: during an up-sweep with len=4, change wave_length to 10 at cnt=258 -> still turns at 260; next up-sweep turns at 266.
- Sawtooth, len=3, from reset -> cnt 257,256,257,258,259,256,257; dir_up stays 1.
- Gating: tick_en=0 for 5 clks, then ch_enable[1]=0 while ch0 runs -> ch1 cnt frozen and pulse_out[1]=0; ch0 unaffected. Ch1 resumes from the same cnt when re-enabled.
